// File: rtl/dram_timing_controller.sv
// Bitmap DRAM timing: 16-clock frame, video fetch in S0-S7, CPU access in S8-S15.
// Define DRAM_REFRESH_EN to fill idle CPU slots with RAS-only refresh.

module dram_timing_controller (
   input  logic        clk,
   input  logic        RESETn,
   input  logic [13:0] video_addr,
   output logic        vid_load,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [14:0] cpu_addr,
   input  logic [1:0]  cpu_mask,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_ack,
   input  logic [7:0]  data_from_dram,
   output logic [7:0]  data_to_dram,
   output logic        RASn,
   output logic        CASn,
   output logic [7:0]  DRAB,
   output logic        DRWR,
   output logic        DRLn,
   output logic        DRHn,
   output logic        WP0n,
   output logic        WP1n,
   output logic        WP2n,
   output logic        WP3n
);

   typedef enum logic [3:0] {
      S0, S1, S2, S3, S4, S5, S6, S7,
      S8, S9, S10, S11, S12, S13, S14, S15
   } state_t;

   state_t      state;
   state_t      nxt;
   logic [13:0] vid_word;
   logic        busy;
   logic        cpu_we_q;
   logic [14:0] cpu_addr_q;
   logic [1:0]  cpu_mask_q;
`ifdef DRAM_REFRESH_EN
   logic [7:0]  rfsh_row;
   logic        rfsh_act;
`endif

   // Outputs are decoded from the state being entered so each registered
   // output is already valid during the cycle of its named state.
   assign nxt = state_t'(state + 4'd1);

   always_ff @(posedge clk) begin
      if (!RESETn) begin
         state        <= S0;
         RASn         <= 1'b1;
         CASn         <= 1'b1;
         DRWR         <= 1'b1;
         DRLn         <= 1'b1;
         DRHn         <= 1'b1;
         WP0n         <= 1'b1;
         WP1n         <= 1'b1;
         WP2n         <= 1'b1;
         WP3n         <= 1'b1;
         DRAB         <= 8'd0;
         cpu_rdata    <= 8'd0;
         data_to_dram <= 8'd0;
         cpu_ack      <= 1'b0;
         vid_load     <= 1'b0;
         busy         <= 1'b0;
`ifdef DRAM_REFRESH_EN
         rfsh_row     <= 8'd0;
         rfsh_act     <= 1'b0;
`endif
      end else begin
         state    <= nxt;
         vid_load <= (nxt == S4);
         cpu_ack  <= 1'b0;
         case (nxt)
            S0: begin
               vid_word <= video_addr;
               DRAB     <= video_addr[7:0];
            end
            S1: RASn <= 1'b0;
            S2: DRAB <= {2'b00, vid_word[13:8]};
            S3: begin
               CASn <= 1'b0;
               DRWR <= 1'b0;
            end
            S5: begin
               RASn <= 1'b1;
               CASn <= 1'b1;
               DRWR <= 1'b1;
            end
            S8: begin
               if (cpu_req) begin
                  busy         <= 1'b1;
                  cpu_we_q     <= cpu_we;
                  cpu_addr_q   <= cpu_addr;
                  cpu_mask_q   <= cpu_mask;
                  data_to_dram <= cpu_wdata;
                  DRAB         <= cpu_addr[8:1];
               end
`ifdef DRAM_REFRESH_EN
               if (!cpu_req) DRAB <= rfsh_row;
               rfsh_act <= !cpu_req;
`endif
            end
            S9: begin
               if (busy) RASn <= 1'b0;
`ifdef DRAM_REFRESH_EN
               if (rfsh_act) RASn <= 1'b0;
`endif
            end
            S10: begin
               if (busy) begin
                  DRAB <= {2'b00, cpu_addr_q[14:9]};
                  DRLn <= cpu_addr_q[0];
                  DRHn <= !cpu_addr_q[0];
                  DRWR <= cpu_we_q;
                  // Nibble strobes stay low through S12; a zero mask writes nothing.
                  if (cpu_we_q) begin
                     WP0n <= !(!cpu_addr_q[0] && cpu_mask_q[0]);
                     WP1n <= !(!cpu_addr_q[0] && cpu_mask_q[1]);
                     WP2n <= !(cpu_addr_q[0] && cpu_mask_q[0]);
                     WP3n <= !(cpu_addr_q[0] && cpu_mask_q[1]);
                  end
               end
            end
            S11: if (busy) CASn <= 1'b0;
            S13: begin
               if (busy && !cpu_we_q) cpu_rdata <= data_from_dram;
               RASn <= 1'b1;
               CASn <= 1'b1;
               DRWR <= 1'b1;
               DRLn <= 1'b1;
               DRHn <= 1'b1;
               WP0n <= 1'b1;
               WP1n <= 1'b1;
               WP2n <= 1'b1;
               WP3n <= 1'b1;
`ifdef DRAM_REFRESH_EN
               if (rfsh_act) rfsh_row <= rfsh_row + 8'd1;
               rfsh_act <= 1'b0;
`endif
            end
            S15: begin
               cpu_ack <= busy;
               busy    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dram_timing_controller.sv
// Bench for dram_timing_controller: directed vectors plus randomized accesses
// checked cycle by cycle against a frame-window reference model.

module tb_dram_timing_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        RESETn;
   logic [13:0] video_addr;
   logic        vid_load;
   logic        cpu_req, cpu_we;
   logic [14:0] cpu_addr;
   logic [1:0]  cpu_mask;
   logic [7:0]  cpu_wdata, cpu_rdata;
   logic        cpu_ack;
   logic [7:0]  data_from_dram, data_to_dram;
   logic        RASn, CASn;
   logic [7:0]  DRAB;
   logic        DRWR, DRLn, DRHn, WP0n, WP1n, WP2n, WP3n;

   dram_timing_controller dut (
      .clk(clk), .RESETn(RESETn), .video_addr(video_addr), .vid_load(vid_load),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_mask(cpu_mask),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .data_from_dram(data_from_dram), .data_to_dram(data_to_dram),
      .RASn(RASn), .CASn(CASn), .DRAB(DRAB), .DRWR(DRWR), .DRLn(DRLn), .DRHn(DRHn),
      .WP0n(WP0n), .WP1n(WP1n), .WP2n(WP2n), .WP3n(WP3n)
   );

`ifdef DRAM_REFRESH_EN
   localparam bit REF_EN = 1'b1;
`else
   localparam bit REF_EN = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: position in frame plus what was captured for this frame.
   int          phase;
   bit          va_ok;
   int          va_m;
   bit          a_act, a_we;
   int          a_addr, a_mask, a_wdata, a_rdata;
   bit          rf_act;
   int          rf_row;
   bit          rnd_drive;

   typedef struct {
      logic        we;
      logic [14:0] addr;
      logic [1:0]  mask;
      logic [7:0]  wdata;
      logic [7:0]  dram;
      logic [7:0]  e_row;
      logic [7:0]  e_col;
      logic        e_drl;
      logic        e_drh;
      logic [3:0]  e_wp;
      logic [7:0]  e_rdata;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s phase=%0d got=%0h want=%0h", name, phase, act, exp);
      end
   endtask

   task automatic check_outputs();
      int  p, word, exp_drab;
      bit  win, hi, rf;
      if (!RESETn) begin
         chk("rst_RASn", RASn, 1); chk("rst_CASn", CASn, 1); chk("rst_DRWR", DRWR, 1);
         chk("rst_DRLn", DRLn, 1); chk("rst_DRHn", DRHn, 1);
         chk("rst_WP", {WP3n, WP2n, WP1n, WP0n}, 4'hF);
         chk("rst_DRAB", DRAB, 0); chk("rst_rdata", cpu_rdata, 0);
         chk("rst_wdata", data_to_dram, 0); chk("rst_ack", cpu_ack, 0);
         chk("rst_vid_load", vid_load, 0);
      end else begin
         p    = phase;
         word = a_addr / 2;
         hi   = (a_addr % 2) == 1;
         win  = a_act && p >= 10 && p <= 12;
         rf   = rf_act && p >= 9 && p <= 12;
         chk("RASn", RASn, !((p >= 1 && p <= 4) || (a_act && p >= 9 && p <= 12) || rf));
         chk("CASn", CASn, !((p >= 3 && p <= 4) || (a_act && p >= 11 && p <= 12)));
         chk("DRWR", DRWR, !((p >= 3 && p <= 4) || (win && !a_we)));
         chk("DRLn", DRLn, !(win && !hi));
         chk("DRHn", DRHn, !(win && hi));
         chk("WP0n", WP0n, !(win && a_we && !hi && a_mask[0]));
         chk("WP1n", WP1n, !(win && a_we && !hi && a_mask[1]));
         chk("WP2n", WP2n, !(win && a_we && hi && a_mask[0]));
         chk("WP3n", WP3n, !(win && a_we && hi && a_mask[1]));
         chk("vid_load", vid_load, p == 4);
         chk("cpu_ack", cpu_ack, a_act && p == 15);
         exp_drab = -1;
         if (p <= 1 && va_ok) exp_drab = va_m % 256;
         else if (p >= 2 && p <= 7 && va_ok) exp_drab = va_m / 256;
         else if (p >= 8 && a_act) exp_drab = (p <= 9) ? word % 256 : word / 256;
         else if (p >= 8 && p <= 12 && rf_act) exp_drab = rf_row;
         if (exp_drab >= 0) chk("DRAB", DRAB, exp_drab);
         if (a_act && !a_we && p >= 13) chk("cpu_rdata", cpu_rdata, a_rdata);
         if (a_act && a_we && p >= 8) chk("data_to_dram", data_to_dram, a_wdata);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (!RESETn) begin
         phase = 0; va_ok = 0; a_act = 0; rf_act = 0; rf_row = 0;
      end else begin
         phase = (phase + 1) % 16;
         if (phase == 0) begin
            va_m = int'(video_addr); va_ok = 1; a_act = 0;
         end
         if (phase == 8) begin
            a_act  = cpu_req;
            rf_act = REF_EN && !cpu_req;
            if (cpu_req) begin
               a_we = cpu_we; a_addr = int'(cpu_addr);
               a_mask = int'(cpu_mask); a_wdata = int'(cpu_wdata);
            end
         end
         if (phase == 13) begin
            if (a_act && !a_we) a_rdata = int'(data_from_dram);
            if (rf_act) rf_row = (rf_row + 1) % 256;
         end
      end
      @(negedge clk);
      check_outputs();
      if (rnd_drive) begin
         video_addr     = 14'($urandom);
         data_from_dram = 8'($urandom);
      end
   endtask

   task automatic wait_phase(input int tgt);
      int n = 0;
      while (phase != tgt && n < 40) begin
         step();
         n++;
      end
      if (phase != tgt) begin
         n_tests++; n_fail++;
         $display("FAIL wait_phase got=%0d want=%0d", phase, tgt);
      end
   endtask

   task automatic do_reset(input int cycles);
      RESETn  = 1'b0;
      cpu_req = 1'b0;
      repeat (cycles) step();
      RESETn = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0] row_s, col_s, rd_s;
      logic       drl_s, drh_s, ack_s;
      logic [3:0] wp10, wp12;
      rnd_drive = 1'b0;
      wait_phase(7);
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_mask = v.mask;
      cpu_wdata = v.wdata; data_from_dram = v.dram;
      ack_s = 1'b0; rd_s = 8'd0; row_s = 8'd0; col_s = 8'd0;
      drl_s = 1'b1; drh_s = 1'b1; wp10 = 4'hF; wp12 = 4'hF;
      repeat (8) begin
         step();
         case (phase)
            8:  row_s = DRAB;
            10: begin col_s = DRAB; drl_s = DRLn; drh_s = DRHn; wp10 = {WP3n, WP2n, WP1n, WP0n}; end
            12: wp12 = {WP3n, WP2n, WP1n, WP0n};
            15: begin ack_s = cpu_ack; rd_s = cpu_rdata; end
            default: ;
         endcase
      end
      cpu_req = 1'b0;
      chk("vec_row", row_s, v.e_row);
      chk("vec_col", col_s, v.e_col);
      chk("vec_DRLn", drl_s, v.e_drl);
      chk("vec_DRHn", drh_s, v.e_drh);
      chk("vec_WP_s10", wp10, v.e_wp);
      chk("vec_WP_s12", wp12, v.e_wp);
      chk("vec_ack", ack_s, 1);
      if (!v.we) chk("vec_rdata", rd_s, v.e_rdata);
   endtask

   initial begin
      int lat;
      bit seen;
      logic [7:0] vdrab [8];
      logic       vcas  [8];
      vecs[0] = '{1'b1, 15'h1235, 2'b11, 8'hA7, 8'h00, 8'h1A, 8'h09, 1'b1, 1'b0, 4'b0011, 8'h00};
      vecs[1] = '{1'b0, 15'h0004, 2'b00, 8'h00, 8'h3C, 8'h02, 8'h00, 1'b0, 1'b1, 4'b1111, 8'h3C};
      vecs[2] = '{1'b1, 15'h0000, 2'b10, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 4'b1101, 8'h00};
      vecs[3] = '{1'b1, 15'h7FFF, 2'b00, 8'h55, 8'h00, 8'hFF, 8'h3F, 1'b1, 1'b0, 4'b1111, 8'h00};
      vecs[4] = '{1'b0, 15'h4A21, 2'b11, 8'h00, 8'hC9, 8'h10, 8'h25, 1'b1, 1'b0, 4'b1111, 8'hC9};
      vecs[5] = '{1'b1, 15'h0102, 2'b01, 8'hE1, 8'h00, 8'h81, 8'h00, 1'b0, 1'b1, 4'b1110, 8'h00};
      vdrab = '{8'h5C, 8'h5C, 8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h2A};
      vcas  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

      phase = 0; va_ok = 0; a_act = 0; rf_act = 0; rf_row = 0; rnd_drive = 0;
      cpu_we = 0; cpu_addr = 0; cpu_mask = 0; cpu_wdata = 0;
      video_addr = 14'h2A5C; data_from_dram = 0;
      do_reset(3);

      // Video slot with a fixed fetch address.
      wait_phase(15);
      video_addr = 14'h2A5C;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("vid_DRAB", DRAB, vdrab[k]);
         chk("vid_CASn", CASn, vcas[k]);
         chk("vid_pulse", vid_load, k == 4);
      end

      foreach (vecs[i]) run_vec(vecs[i]);

      // Best and worst case request-to-ack latency.
      rnd_drive = 1'b1;
      wait_phase(7);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h2222;
      lat = 0;
      do begin step(); lat++; end while (!cpu_ack && lat < 40);
      chk("lat_best", lat, 8);
      cpu_req = 1'b0;
      wait_phase(8);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h1111; cpu_mask = 2'b11;
      lat = 0;
      do begin step(); lat++; end while (!cpu_ack && lat < 40);
      chk("lat_worst", lat, 23);
      cpu_req = 1'b0;
      step();

      // Randomized accesses with random gaps and video addresses.
      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 20)) step();
         cpu_req = 1'b1; cpu_we = 1'($urandom); cpu_addr = 15'($urandom);
         cpu_mask = 2'($urandom); cpu_wdata = 8'($urandom);
         lat = 0;
         do begin step(); lat++; end while (!cpu_ack && lat < 40);
         chk("rand_ack", cpu_ack, 1);
         cpu_req = 1'b0;
         step();
      end

      // Reset held for 3 clocks in the middle of a write.
      wait_phase(7);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0001; cpu_mask = 2'b11;
      wait_phase(11);
      chk("mid_WP_low", {WP3n, WP2n}, 2'b00);
      do_reset(3);
      seen = 1'b0;
      repeat (40) begin
         step();
         if (cpu_ack) seen = 1'b1;
      end
      chk("mid_no_ack", seen, 0);

`ifdef DRAM_REFRESH_EN
      do_reset(2);
      for (int f = 0; f < 257; f++) begin
         wait_phase(8);
         chk("rfsh_row", DRAB, f % 256);
         step();
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout phase=%0d", phase);
      $fatal(1, "timeout");
   end

endmodule
